// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one WIDTH-bit up-counter between two requesters.
// Each grant runs q from 0 to the winner's latched length, then pulses done.
module counter_sched #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             done_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [1:0]       gnt_n;
    logic [WIDTH-1:0] q_n;
    logic             done_n;
    logic             done_id_n;
    logic             ptr, ptr_n;
    logic             id, id_n;
    logic [WIDTH-1:0] len_r, len_n;
    logic             win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            q       <= '0;
            done    <= 1'b0;
            done_id <= 1'b0;
            ptr     <= 1'b0;
            id      <= 1'b0;
            len_r   <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            q       <= q_n;
            done    <= done_n;
            done_id <= done_id_n;
            ptr     <= ptr_n;
            id      <= id_n;
            len_r   <= len_n;
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        q_n       = q;
        done_n    = 1'b0;
        done_id_n = done_id;
        ptr_n     = ptr;
        id_n      = id;
        len_n     = len_r;
        win       = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    // Contention resolved by ptr; a lone request wins outright.
                    win     = (req == 2'b11) ? ptr : req[1];
                    state_n = RUN;
                    gnt_n   = win ? 2'b10 : 2'b01;
                    q_n     = '0;
                    id_n    = win;
                    len_n   = win ? len1 : len0;
                end
            end
            RUN: begin
                if (!req[id]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = ~id;
                end else if (q == len_r) begin
                    state_n   = DONE;
                    done_n    = 1'b1;
                    done_id_n = id;
                end else begin
                    q_n = q + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = '0;
                ptr_n   = ~id;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Scheduler that shares one WIDTH-bit up-counter between two requesters.
- Each requester asks for a timed interval of its own length. The block arbitrates round-robin, runs the counter from 0 to the granted length, then signals completion.
- Sits between requester logic and the shared counter resource. It also exposes the live count.

Parameters:
- WIDTH, 4, counter and length width in bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  level request per requester; held high until done or withdrawn.
- len0  input  WIDTH  terminal count for requester 0; sampled at grant.
- len1  input  WIDTH  terminal count for requester 1; sampled at grant.
- gnt  output  2  one-hot grant or all-zero; registered.
- busy  output  1  high whenever state is not IDLE.
- q  output  WIDTH  shared counter value; registered.
- done  output  1  one-cycle completion pulse; registered.
- done_id  output  1  index of the requester that completed; valid while done is high.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE, gnt=00, q=0, done=0, done_id=0, ptr=0, busy=0. Reset has priority over every other event, including mid-RUN. There is no done pulse for a run killed by reset.
- States: IDLE, RUN, DONE.
- Arbitration in IDLE:
  - Only one req bit high: that requester wins.
  - Both high: the requester indexed by ptr wins.
  - Neither high: stay in IDLE.
- Grant edge:
  - State goes to RUN.
  - gnt is set to one-hot of the winner.
  - q is set to 0.
  - The winner's len is latched into len_r; later changes to len0/len1 are ignored.
- RUN, at each edge:
  - If req[id] is low: abort. Go to IDLE, gnt=00, no done pulse, ptr=~id, q holds its value.
  - Else if q==len_r: go to DONE, done=1, done_id=id, q holds.
  - Else: q=q+1.
- DONE (exactly one cycle):
  - done=1 and gnt is still asserted.
  - Next edge: IDLE, gnt=00, done=0, ptr=~id.
- Timing:
  - Grant visible 1 cycle after req is sampled high in IDLE.
  - RUN lasts len_r+1 cycles (q=0..len_r).
  - done is high in the cycle after q first equals len_r.
  - Total gnt-high time is len_r+2 cycles.
- At least one IDLE cycle separates consecutive grants. busy=0 in that cycle.
- len_r=0: q=0 for one RUN cycle, then DONE.
- len_r=2^WIDTH-1: q reaches all-ones, then DONE; q never wraps to 0 within a run.
- In IDLE, q holds the last value reached; it is only cleared by a new grant or by reset.
- A req from the non-granted requester during RUN/DONE is held off; it is served in the IDLE cycle that follows.
- A req dropping in the DONE cycle has no effect; done still pulses.

Test Plan:
- Reset, then req=01 with len0=3 -> gnt=01 one cycle later; q=0,1,2,3 on successive cycles; done=1, done_id=0 next cycle; then gnt=00, busy=0.
- After reset, req=11 with len0=1, len1=2 -> requester 0 served first (q 0,1, done_id=0); one IDLE cycle; then gnt=10, q 0,1,2, done_id=1; ptr ends at 0.
- req0 held continuously with req1 also high -> grants alternate 0,1,0; no requester is granted twice in a row.
- len0=15 -> q climbs 0..15 and holds 15 through DONE and IDLE; done pulses once; no wrap to 0.
- req1 granted with len1=10; drop req1 when q=4 -> next edge IDLE, gnt=00, done stays 0, q holds 4; pending req0 granted next.
- reset asserted when q=5 mid-RUN -> next edge q=0, gnt=00, busy=0, done=0; len0=0 run afterwards -> q=0 for one cycle, then done.
